// File: rtl/game_round_ctrl.sv
// game_round_ctrl: reaction-game round FSM issuing LFSR commands, timing answers
// against a shrinking deadline, and tracking score, lives and result pulses.
module game_round_ctrl #(
  parameter int          NUM_CMDS        = 6,
  parameter int          CMD_W           = 3,
  parameter bit          NOT_EN          = 1'b1,
  parameter int          NUM_LIVES       = 3,
  parameter int          LIFE_W          = 2,
  parameter int          SCORE_W         = 8,
  parameter int          TIMER_W         = 28,
  parameter int          TIMEOUT_CYCLES  = 150000000,
  parameter int          MIN_TIMEOUT     = 50000000,
  parameter int          TIMEOUT_STEP    = 5000000,
  parameter int          FEEDBACK_CYCLES = 50000000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               key_valid_i,
  input  logic [CMD_W-1:0]   key_cmd_i,
  output logic [CMD_W-1:0]   cmd_o,
  output logic               cmd_not_o,
  output logic               cmd_valid_o,
  output logic [LIFE_W-1:0]  lives_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               result_correct_o,
  output logic               result_wrong_o,
  output logic               game_over_o
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_KEY, CORRECT, WRONG, GAME_OVER} state_e;
  localparam logic [TIMER_W-1:0] TO_T   = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] MIN_T  = TIMER_W'(MIN_TIMEOUT);
  localparam logic [TIMER_W-1:0] STEP_T = TIMER_W'(TIMEOUT_STEP);
  localparam logic [TIMER_W-1:0] FB_T   = TIMER_W'(FEEDBACK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ONE_T  = TIMER_W'(1);
  localparam logic [LIFE_W-1:0]  LIVES_T = LIFE_W'(NUM_LIVES);
  localparam logic [CMD_W:0]     NCMD   = (CMD_W+1)'(NUM_CMDS);
  state_e             state_q;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [TIMER_W-1:0] timer_q, deadline_q, deadline_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIFE_W-1:0]  lives_q;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               cmd_not_q, cmd_valid_q, res_c_q, res_w_q, game_over_q, hit, done;
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cmd_d = CMD_W'(32'(lfsr_q[7:0]) % NUM_CMDS);
    hit = cmd_not_q ? (key_cmd_i != cmd_q && {1'b0, key_cmd_i} < NCMD) : key_cmd_i == cmd_q;
    done = key_valid_i || timer_q == '0;
    score_d = &score_q ? score_q : score_q + SCORE_W'(1);
    // deadline never drops below MIN_TIMEOUT, so the subtraction cannot wrap
    deadline_d = deadline_q - MIN_T >= STEP_T ? deadline_q - STEP_T : MIN_T;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      cmd_q       <= '0;
      cmd_not_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      lives_q     <= LIVES_T;
      score_q     <= '0;
      res_c_q     <= 1'b0;
      res_w_q     <= 1'b0;
      game_over_q <= 1'b0;
      deadline_q  <= TO_T;
      timer_q     <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      res_c_q <= 1'b0;
      res_w_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) state_q <= ISSUE;
        ISSUE: begin
          cmd_q       <= cmd_d;
          cmd_not_q   <= lfsr_q[15] & NOT_EN;
          cmd_valid_q <= 1'b1;
          timer_q     <= deadline_q - ONE_T;
          state_q     <= WAIT_KEY;
        end
        WAIT_KEY: begin
          if (done) begin
            cmd_valid_q <= 1'b0;
            timer_q     <= FB_T;
            if (key_valid_i && hit) begin
              res_c_q    <= 1'b1;
              score_q    <= score_d;
              deadline_q <= deadline_d;
              state_q    <= CORRECT;
            end else begin
              res_w_q <= 1'b1;
              lives_q <= lives_q - LIFE_W'(1);
              state_q <= WRONG;
            end
          end else timer_q <= timer_q - ONE_T;
        end
        CORRECT, WRONG: begin
          if (timer_q != '0) timer_q <= timer_q - ONE_T;
          else if (state_q == WRONG && lives_q == '0) begin
            game_over_q <= 1'b1;
            state_q     <= GAME_OVER;
          end else state_q <= ISSUE;
        end
        GAME_OVER: begin
          if (start_i) begin
            lives_q     <= LIVES_T;
            score_q     <= '0;
            deadline_q  <= TO_T;
            game_over_q <= 1'b0;
            state_q     <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cmd_o            = cmd_q;
  assign cmd_not_o        = cmd_not_q;
  assign cmd_valid_o      = cmd_valid_q;
  assign lives_o          = lives_q;
  assign score_o          = score_q;
  assign result_correct_o = res_c_q;
  assign result_wrong_o   = res_w_q;
  assign game_over_o      = game_over_q;
endmodule
